// File: rtl/sfr_timer_v1.sv
// sfr_timer_v1: prescaled up-counter with period wrap, one-shot mode and
// overflow flag feedback into the control SFR via per-bit HW updates.
//
// Ports:
//   sys_clk       - system clock, rising edge
//   sys_rst       - asynchronous active-high reset
//   ctrl_dout     - control SFR value (EN, ONESHOT, IE, PS, OVF)
//   period_dout   - period SFR value; counter wraps to 0 after reaching it
//   cnt_wen       - one-cycle SW write strobe for the counter
//   cnt_wdata     - SW counter write value
//   tmr_hw_update - per-bit HW-update request to the control SFR
//   tmr_hw_value  - per-bit HW-update value to the control SFR
//   cnt_value     - registered counter value
//   tmr_irq       - level interrupt (OVF & IE)
module sfr_timer_v1 #(
    parameter int TMR_WIDTH = 32,
    parameter int PS_WIDTH  = 4
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [TMR_WIDTH-1:0] ctrl_dout,
    input  logic [TMR_WIDTH-1:0] period_dout,
    input  logic                 cnt_wen,
    input  logic [TMR_WIDTH-1:0] cnt_wdata,
    output logic [TMR_WIDTH-1:0] tmr_hw_update,
    output logic [TMR_WIDTH-1:0] tmr_hw_value,
    output logic [TMR_WIDTH-1:0] cnt_value,
    output logic                 tmr_irq
);

    // Prescaler counter is wide enough for the largest divider 2^(2^PS_WIDTH-1).
    localparam int PSC_W = (1 << PS_WIDTH) - 1;

    localparam int BIT_EN   = 0;
    localparam int BIT_OS   = 1;
    localparam int BIT_IE   = 2;
    localparam int BIT_PS   = 4;
    localparam int BIT_OVF  = 8;

    // Control field decode
    logic                ctrl_en;
    logic                ctrl_os;
    logic                ctrl_ie;
    logic                ctrl_ovf;
    logic [PS_WIDTH-1:0] ctrl_ps;

    assign ctrl_en  = ctrl_dout[BIT_EN];
    assign ctrl_os  = ctrl_dout[BIT_OS];
    assign ctrl_ie  = ctrl_dout[BIT_IE];
    assign ctrl_ovf = ctrl_dout[BIT_OVF];
    assign ctrl_ps  = ctrl_dout[BIT_PS +: PS_WIDTH];

    // Bits of the control word this block never looks at.
    logic unused_ctrl_bits;
    assign unused_ctrl_bits = ^{ctrl_dout[TMR_WIDTH-1:BIT_OVF+1],
                                ctrl_dout[3]};

    // State
    logic [TMR_WIDTH-1:0] cnt_q,    cnt_d;
    logic [PSC_W-1:0]     ps_cnt_q, ps_cnt_d;
    logic                 ovf_q,    ovf_d;
    logic                 clr_en_q, clr_en_d;
    logic                 done_q,   done_d;

    // Datapath intermediates
    logic                 run;
    logic [PSC_W-1:0]     ps_mask;
    logic                 tick;
    logic                 at_period;
    logic                 wrap;

    assign run = ctrl_en & ~done_q;

    // Mask of the low PS bits of the prescaler; all-ones there means tick.
    always_comb begin
        ps_mask = '0;
        for (int i = 0; i < PSC_W; i++) begin
            ps_mask[i] = (i < int'(ctrl_ps));
        end
    end

    assign tick      = run & ((ps_cnt_q & ps_mask) == ps_mask);
    assign at_period = (cnt_q == period_dout);
    // A SW counter write suppresses any wrap in the same cycle.
    assign wrap      = ~cnt_wen & tick & at_period;

    // Prescaler next state
    always_comb begin
        ps_cnt_d = ps_cnt_q;
        if (cnt_wen) begin
            ps_cnt_d = '0;
        end else if (run) begin
            ps_cnt_d = ps_cnt_q + 1'b1;
        end else begin
            ps_cnt_d = '0;
        end
    end

    // Counter next state; counting past the period (after a SW write or a
    // period reduction) simply rolls over at full width with no wrap event.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_wen) begin
            cnt_d = cnt_wdata;
        end else if (wrap) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Overflow pulse, one-shot EN clear request and the done blocker.
    // done holds off counting until the SFR's EN has actually dropped.
    always_comb begin
        ovf_d    = wrap;
        clr_en_d = wrap & ctrl_os;
        done_d   = done_q;
        if (!ctrl_en) begin
            done_d = 1'b0;
        end else if (wrap && ctrl_os) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt_q    <= '0;
            ps_cnt_q <= '0;
            ovf_q    <= 1'b0;
            clr_en_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            ps_cnt_q <= ps_cnt_d;
            ovf_q    <= ovf_d;
            clr_en_q <= clr_en_d;
            done_q   <= done_d;
        end
    end

    // HW-update bundle to the control SFR: set OVF, and clear EN in one-shot.
    always_comb begin
        tmr_hw_update          = '0;
        tmr_hw_value           = '0;
        tmr_hw_update[BIT_OVF] = ovf_q;
        tmr_hw_value[BIT_OVF]  = ovf_q;
        tmr_hw_update[BIT_EN]  = clr_en_q;
        tmr_hw_value[BIT_EN]   = 1'b0;
    end

    assign cnt_value = cnt_q;
    assign tmr_irq   = ctrl_ovf & ctrl_ie;

endmodule

// File: tb/tb_sfr_timer_v1.sv
// Directed testbench for sfr_timer_v1 with a small control-SFR model
// (SW write, per-bit HW update with HW priority) closing the feedback loop.
module tb_sfr_timer_v1;

    logic        clk;
    logic        rst;
    logic [31:0] ctrl_sfr;
    logic [31:0] period;
    logic        cnt_wen;
    logic [31:0] cnt_wdata;
    logic [31:0] hw_upd;
    logic [31:0] hw_val;
    logic [31:0] cnt_value;
    logic        irq;

    logic        sw_wen;
    logic [31:0] sw_wdata;

    int total;
    int bad;

    sfr_timer_v1 dut (
        .sys_clk       (clk),
        .sys_rst       (rst),
        .ctrl_dout     (ctrl_sfr),
        .period_dout   (period),
        .cnt_wen       (cnt_wen),
        .cnt_wdata     (cnt_wdata),
        .tmr_hw_update (hw_upd),
        .tmr_hw_value  (hw_val),
        .cnt_value     (cnt_value),
        .tmr_irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control SFR model: HW update has priority over a SW write per bit.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_sfr <= 32'h0;
        end else begin
            logic [31:0] nxt;
            nxt = sw_wen ? sw_wdata : ctrl_sfr;
            for (int i = 0; i < 32; i++) begin
                if (hw_upd[i]) nxt[i] = hw_val[i];
            end
            ctrl_sfr <= nxt;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sfr_write(input logic [31:0] d);
        sw_wen   = 1'b1;
        sw_wdata = d;
        step();
        sw_wen   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        total++;
        if (cnt_value !== 32'h0) begin
            bad++; $display("FAIL reset_cnt got=%h exp=0", cnt_value);
        end
        total++;
        if (hw_upd !== 32'h0 || hw_val !== 32'h0) begin
            bad++; $display("FAIL reset_hw got=%h/%h exp=0/0", hw_upd, hw_val);
        end
        total++;
        if (irq !== 1'b0) begin
            bad++; $display("FAIL reset_irq got=%b exp=0", irq);
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_continuous();
        logic [31:0] ecnt, ehw;
        do_reset();
        period = 32'd3;
        sfr_write(32'h1);
        for (int i = 0; i < 9; i++) begin
            step();
            ecnt = 32'((i + 1) % 4);
            ehw  = (ecnt == 0) ? 32'h100 : 32'h0;
            total++;
            if (cnt_value !== ecnt || hw_upd !== ehw || hw_val !== ehw) begin
                bad++;
                $display("FAIL cont[%0d] got cnt=%h upd=%h val=%h exp cnt=%h upd/val=%h",
                         i, cnt_value, hw_upd, hw_val, ecnt, ehw);
            end
        end
        total++;
        if (ctrl_sfr[8] !== 1'b1 || irq !== 1'b0) begin
            bad++; $display("FAIL cont_ovf got ovf=%b irq=%b exp 1/0", ctrl_sfr[8], irq);
        end
    endtask

    task automatic test_prescaler();
        do_reset();
        period = 32'd1;
        sfr_write(32'h21);
        repeat (3) step();
        total++;
        if (cnt_value !== 32'd0) begin
            bad++; $display("FAIL ps_hold3 got=%h exp=0", cnt_value);
        end
        step();
        total++;
        if (cnt_value !== 32'd1) begin
            bad++; $display("FAIL ps_tick4 got=%h exp=1", cnt_value);
        end
        repeat (4) step();
        total++;
        if (cnt_value !== 32'd0 || hw_upd !== 32'h100) begin
            bad++; $display("FAIL ps_wrap8 got cnt=%h upd=%h exp 0/100", cnt_value, hw_upd);
        end
        repeat (5) step();
        sfr_write(32'h20);
        repeat (10) step();
        total++;
        if (cnt_value !== 32'd1) begin
            bad++; $display("FAIL ps_freeze got=%h exp=1", cnt_value);
        end
        sfr_write(32'h21);
        repeat (3) step();
        total++;
        if (cnt_value !== 32'd1 || hw_upd !== 32'h0) begin
            bad++; $display("FAIL ps_resume3 got cnt=%h upd=%h exp 1/0", cnt_value, hw_upd);
        end
        step();
        total++;
        if (cnt_value !== 32'd0 || hw_upd !== 32'h100) begin
            bad++; $display("FAIL ps_resume4 got cnt=%h upd=%h exp 0/100", cnt_value, hw_upd);
        end
    endtask

    task automatic test_oneshot();
        int errs;
        do_reset();
        period = 32'd2;
        sfr_write(32'h7);
        repeat (2) step();
        total++;
        if (cnt_value !== 32'd2 || hw_upd !== 32'h0) begin
            bad++; $display("FAIL os_pre got cnt=%h upd=%h exp 2/0", cnt_value, hw_upd);
        end
        step();
        total++;
        if (hw_upd !== 32'h101 || hw_val !== 32'h100 || cnt_value !== 32'd0) begin
            bad++;
            $display("FAIL os_pulse got upd=%h val=%h cnt=%h exp 101/100/0",
                     hw_upd, hw_val, cnt_value);
        end
        step();
        total++;
        if (ctrl_sfr !== 32'h106 || irq !== 1'b1 || hw_upd !== 32'h0) begin
            bad++;
            $display("FAIL os_sfr got ctrl=%h irq=%b upd=%h exp 106/1/0",
                     ctrl_sfr, irq, hw_upd);
        end
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (cnt_value !== 32'd0 || hw_upd !== 32'h0 || irq !== 1'b1) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++; $display("FAIL os_idle bad_cycles=%0d exp=0", errs);
        end
        sfr_write(32'h6);
        total++;
        if (irq !== 1'b0) begin
            bad++; $display("FAIL os_irq_clr got=%b exp=0", irq);
        end
        sfr_write(32'h7);
        step();
        total++;
        if (cnt_value !== 32'd1) begin
            bad++; $display("FAIL os_restart got=%h exp=1", cnt_value);
        end
    endtask

    task automatic test_sw_write();
        logic [31:0] exp_seq [9];
        logic [31:0] ehw;
        exp_seq = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1, 32'h2,
                    32'h3, 32'h4, 32'h5, 32'h0};
        do_reset();
        period = 32'd5;
        sfr_write(32'h1);
        repeat (5) step();
        total++;
        if (cnt_value !== 32'd5) begin
            bad++; $display("FAIL sw_pre got=%h exp=5", cnt_value);
        end
        cnt_wen   = 1'b1;
        cnt_wdata = 32'h10;
        step();
        cnt_wen   = 1'b0;
        total++;
        if (cnt_value !== 32'h10 || hw_upd !== 32'h0) begin
            bad++; $display("FAIL sw_win got cnt=%h upd=%h exp 10/0", cnt_value, hw_upd);
        end
        cnt_wen   = 1'b1;
        cnt_wdata = 32'hFFFFFFFD;
        step();
        cnt_wen   = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step();
            ehw = (i == 8) ? 32'h100 : 32'h0;
            total++;
            if (cnt_value !== exp_seq[i] || hw_upd !== ehw) begin
                bad++;
                $display("FAIL sw_roll[%0d] got cnt=%h upd=%h exp %h/%h",
                         i, cnt_value, hw_upd, exp_seq[i], ehw);
            end
        end
    endtask

    task automatic test_period_zero();
        logic [31:0] ehw;
        do_reset();
        period = 32'd0;
        sfr_write(32'h11);
        for (int i = 0; i < 6; i++) begin
            step();
            ehw = ((i % 2) == 1) ? 32'h100 : 32'h0;
            total++;
            if (cnt_value !== 32'd0 || hw_upd !== ehw) begin
                bad++;
                $display("FAIL p0[%0d] got cnt=%h upd=%h exp 0/%h",
                         i, cnt_value, hw_upd, ehw);
            end
        end
        sfr_write(32'h11);
        total++;
        if (ctrl_sfr[8] !== 1'b1) begin
            bad++; $display("FAIL p0_collide got ovf=%b exp=1", ctrl_sfr[8]);
        end
        sfr_write(32'h11);
        total++;
        if (ctrl_sfr[8] !== 1'b0) begin
            bad++; $display("FAIL p0_clear got ovf=%b exp=0", ctrl_sfr[8]);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        period = 32'd7;
        sfr_write(32'h1);
        repeat (7) step();
        total++;
        if (cnt_value !== 32'd7) begin
            bad++; $display("FAIL ar_pre got=%h exp=7", cnt_value);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (cnt_value !== 32'd0) begin
            bad++; $display("FAIL ar_cnt got=%h exp=0", cnt_value);
        end
        step();
        rst = 1'b0;
        sfr_write(32'h1);
        repeat (8) step();
        total++;
        if (hw_upd !== 32'h100) begin
            bad++; $display("FAIL ar_ovf_pre got=%h exp=100", hw_upd);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (hw_upd !== 32'h0 || hw_val !== 32'h0 || cnt_value !== 32'h0) begin
            bad++;
            $display("FAIL ar_ovf got upd=%h val=%h cnt=%h exp 0/0/0",
                     hw_upd, hw_val, cnt_value);
        end
        step();
        rst = 1'b0;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b0;
        period    = 32'h0;
        cnt_wen   = 1'b0;
        cnt_wdata = 32'h0;
        sw_wen    = 1'b0;
        sw_wdata  = 32'h0;
        #1;
        test_reset();
        test_continuous();
        test_prescaler();
        test_oneshot();
        test_sw_write();
        test_period_zero();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
